// File: rtl/cpu_bus_bridge_if.sv
// Bus bundle between the CPU side, the bridge and the shared narrow slave port.
// The bridge connects through the slave modport; the CPU/device side uses master.
interface cpu_bus_bridge_if #(
  parameter int MEM_W      = 16,
  parameter int NUM_SLAVES = 4
);
  logic                        req;
  logic [31:0]                 addr;
  logic [1:0]                  size;
  logic                        we;
  logic [31:0]                 wdata;
  logic                        busy;
  logic                        ack;
  logic                        err;
  logic [31:0]                 rdata;
  logic [NUM_SLAVES-1:0]       s_sel;
  logic [31:0]                 s_addr;
  logic                        s_we;
  logic [MEM_W-1:0]            s_wdata;
  logic [NUM_SLAVES*MEM_W-1:0] s_rdata;

  modport slave (
    input  req, addr, size, we, wdata, s_rdata,
    output busy, ack, err, rdata, s_sel, s_addr, s_we, s_wdata
  );

  modport master (
    output req, addr, size, we, wdata, s_rdata,
    input  busy, ack, err, rdata, s_sel, s_addr, s_we, s_wdata
  );
endinterface

// File: rtl/cpu_bus_bridge.sv
// CPU-to-device bridge: decodes one 32-bit access onto NUM_SLAVES windows and
// splits it into MEM_W-bit beats, using read-modify-write for sub-width stores.
module cpu_bus_bridge #(
  parameter int                        MEM_W      = 16,
  parameter int                        NUM_SLAVES = 4,
  parameter int                        RD_LAT     = 1,
  parameter logic [32*NUM_SLAVES-1:0]  BASE       = {32'h81300, 32'h80004, 32'h80000, 32'h0},
  parameter logic [32*NUM_SLAVES-1:0]  SIZE       = {32'h100, 32'h12d0, 32'h4, 32'h80000}
) (
  input  logic             clk,
  input  logic             reset_n,
  cpu_bus_bridge_if.slave  bus
);

  localparam int W  = MEM_W / 8;
  localparam int LW = (MEM_W == 8) ? 0 : (MEM_W == 16) ? 1 : 2;
  localparam logic [NUM_SLAVES-1:0] SEL_ONE = 1;

  typedef enum logic [2:0] {IDLE, RD, RDWAIT, MERGE, WR, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [NUM_SLAVES-1:0]  s_sel_q, s_sel_d;
  logic [31:0]            s_addr_q, s_addr_d;
  logic                   s_we_q, s_we_d;
  logic [MEM_W-1:0]       s_wdata_q, s_wdata_d;
  logic [2:0]             sel_idx_q, sel_idx_d;
  logic [1:0]             size_q, size_d;
  logic                   we_q, we_d;
  logic                   full_q, full_d;
  logic [1:0]             off_q, off_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rbuf_q, rbuf_d;
  logic [1:0]             beat_q, beat_d;
  logic [1:0]             last_q, last_d;
  logic [1:0]             wait_q, wait_d;

  logic                   hit;
  logic [2:0]             hit_idx;
  logic [31:0]            hit_rel;
  logic                   misaligned;
  logic                   req_full;

  // Descending scan so the lowest-index matching window is the one kept.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    hit_rel = 32'd0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (({1'b0, bus.addr} >= {1'b0, BASE[32*i +: 32]}) &&
          ({1'b0, bus.addr} <  ({1'b0, BASE[32*i +: 32]} + {1'b0, SIZE[32*i +: 32]}))) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
        hit_rel = bus.addr - BASE[32*i +: 32];
      end
    end
  end

  assign misaligned = (bus.size == 2'd3) ||
                      ((bus.size == 2'd1) && bus.addr[0]) ||
                      ((bus.size == 2'd2) && (bus.addr[1:0] != 2'd0));
  assign req_full   = (int'(bus.size) >= LW);

  logic [MEM_W-1:0] beat_rd;
  logic [31:0]      wsh;
  logic [3:0]       bmask;
  logic [MEM_W-1:0] merged;
  logic [31:0]      rsh;
  logic [31:0]      rsub;
  logic [31:0]      wnext;

  // Lane steering: merge store bytes into a read beat, or extract load bytes.
  always_comb begin
    beat_rd = bus.s_rdata[int'(sel_idx_q) * MEM_W +: MEM_W];
    wsh     = wdata_q << {off_q, 3'b000};
    bmask   = ((size_q == 2'd0) ? 4'b0001 : 4'b0011) << off_q;
    merged  = beat_rd;
    for (int k = 0; k < W; k++) begin
      if (bmask[k]) merged[8*k +: 8] = wsh[8*k +: 8];
    end
    rsh     = 32'(beat_rd) >> {off_q, 3'b000};
    rsub    = (size_q == 2'd0) ? {24'd0, rsh[7:0]} : {16'd0, rsh[15:0]};
    wnext   = wdata_q >> (int'(beat_q + 2'd1) * MEM_W);
  end

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    s_sel_d   = '0;
    s_addr_d  = s_addr_q;
    s_we_d    = 1'b0;
    s_wdata_d = '0;
    sel_idx_d = sel_idx_q;
    size_d    = size_q;
    we_d      = we_q;
    full_d    = full_q;
    off_d     = off_q;
    wdata_d   = wdata_q;
    rbuf_d    = rbuf_q;
    beat_d    = beat_q;
    last_d    = last_q;
    wait_d    = wait_q;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          busy_d    = 1'b1;
          size_d    = bus.size;
          we_d      = bus.we;
          wdata_d   = bus.wdata;
          off_d     = bus.addr[1:0] & 2'(W - 1);
          full_d    = req_full;
          sel_idx_d = hit_idx;
          rbuf_d    = 32'd0;
          beat_d    = 2'd0;
          last_d    = 2'd0;
          if (!hit || misaligned) begin
            state_d = DONE;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            s_addr_d = hit_rel >> LW;
            s_sel_d  = SEL_ONE << hit_idx;
            if (req_full) last_d = 2'((1 << (int'(bus.size) - LW)) - 1);
            if (bus.we && req_full) begin
              state_d   = WR;
              s_we_d    = 1'b1;
              s_wdata_d = bus.wdata[MEM_W-1:0];
            end else begin
              state_d = RD;
            end
          end
        end
      end

      RD: begin
        if (RD_LAT > 1) begin
          state_d = RDWAIT;
          wait_d  = 2'(RD_LAT - 2);
        end else begin
          state_d = MERGE;
        end
      end

      RDWAIT: begin
        if (wait_q == 2'd0) state_d = MERGE;
        else                wait_d  = wait_q - 2'd1;
      end

      // The slave beat is valid in this cycle and captured on its closing edge.
      MERGE: begin
        if (we_q) begin
          state_d   = WR;
          s_sel_d   = SEL_ONE << sel_idx_q;
          s_we_d    = 1'b1;
          s_wdata_d = merged;
        end else begin
          if (full_q) rbuf_d = rbuf_q | (32'(beat_rd) << (int'(beat_q) * MEM_W));
          else        rbuf_d = rsub;
          if (beat_q == last_q) begin
            state_d = DONE;
            ack_d   = 1'b1;
            rdata_d = rbuf_d;
          end else begin
            state_d  = RD;
            beat_d   = beat_q + 2'd1;
            s_addr_d = s_addr_q + 32'd1;
            s_sel_d  = SEL_ONE << sel_idx_q;
          end
        end
      end

      WR: begin
        if (full_q && (beat_q != last_q)) begin
          beat_d    = beat_q + 2'd1;
          s_addr_d  = s_addr_q + 32'd1;
          s_sel_d   = SEL_ONE << sel_idx_q;
          s_we_d    = 1'b1;
          s_wdata_d = wnext[MEM_W-1:0];
        end else begin
          state_d = DONE;
          ack_d   = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
      s_sel_q   <= '0;
      s_addr_q  <= 32'd0;
      s_we_q    <= 1'b0;
      s_wdata_q <= '0;
      sel_idx_q <= 3'd0;
      size_q    <= 2'd0;
      we_q      <= 1'b0;
      full_q    <= 1'b0;
      off_q     <= 2'd0;
      wdata_q   <= 32'd0;
      rbuf_q    <= 32'd0;
      beat_q    <= 2'd0;
      last_q    <= 2'd0;
      wait_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      s_sel_q   <= s_sel_d;
      s_addr_q  <= s_addr_d;
      s_we_q    <= s_we_d;
      s_wdata_q <= s_wdata_d;
      sel_idx_q <= sel_idx_d;
      size_q    <= size_d;
      we_q      <= we_d;
      full_q    <= full_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      rbuf_q    <= rbuf_d;
      beat_q    <= beat_d;
      last_q    <= last_d;
      wait_q    <= wait_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.ack     = ack_q;
  assign bus.err     = err_q;
  assign bus.rdata   = rdata_q;
  assign bus.s_sel   = s_sel_q;
  assign bus.s_addr  = s_addr_q;
  assign bus.s_we    = s_we_q;
  assign bus.s_wdata = s_wdata_q;

endmodule
